// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches to instruction memory
// and buffers in-order responses in a DEPTH-entry FIFO. Redirects flush the queue and drop stale responses.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [CW-1:0] r_cnt, r_out, r_disc;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_fetch_pc, r_rsp_pc;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_acc, w_pop, w_push;
  logic [CW-1:0] w_rsp_dec;
  logic [31:0]   w_redir_pc;

  // Queued plus in-flight must stay within DEPTH so every kept response has a slot.
  assign w_inflight     = {1'b0, r_cnt} + {1'b0, r_out};
  assign imem_req_valid = rst_n && !redirect_valid && (w_inflight < LIMIT);
  assign imem_req_addr  = r_fetch_pc;

  assign inst_valid = (r_cnt != '0);
  assign inst_data  = r_data[r_rptr];
  assign inst_pc    = r_pc[r_rptr];

  assign w_acc      = imem_req_valid & imem_req_ready;
  assign w_pop      = inst_valid & inst_ready;
  assign w_push     = imem_rsp_valid & !redirect_valid & (r_disc == '0);
  assign w_rsp_dec  = CW'(imem_rsp_valid);
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_out      <= '0;
      r_disc     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      // Every response retires one in-flight fetch, kept or dropped.
      r_out <= r_out + CW'(w_acc) - w_rsp_dec;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_cnt      <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_disc     <= r_out - w_rsp_dec;
      end else begin
        if (w_acc)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) begin
          r_data[r_wptr] <= imem_rsp_data;
          r_pc[r_wptr]   <= r_rsp_pc;
          r_wptr         <= r_wptr + AW'(1);
          r_rsp_pc       <= r_rsp_pc + 32'd4;
        end
        if (w_pop)
          r_rptr <= r_rptr + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (imem_rsp_valid && r_disc != '0)
          r_disc <= r_disc - CW'(1);
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries and the cap on queued-plus-in-flight fetches (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  instruction word returned; in order, at least 1 cycle after its request is accepted.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken: flush and restart fetch.
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 inst_valid  output  1  queue head holds a valid instruction.
REQ-013 inst_ready  input  1  core consumes queue head.
REQ-014 inst_data  output  32  instruction at queue head.
REQ-015 inst_pc  output  32  address of inst_data.

Function
REQ-016 Request accepted when imem_req_valid and imem_req_ready are both high in the same cycle.
REQ-017 Instruction consumed when inst_valid and inst_ready are both high in the same cycle.
REQ-018 imem_req_valid high iff redirect_valid low and (queue count + outstanding) < DEPTH, using registered counts only.
REQ-019 imem_req_addr equals fetch_pc; fetch_pc advances by 4 on each accepted request, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-020 outstanding increments per accepted request and decrements per imem_rsp_valid; both in one cycle leaves it unchanged.
REQ-021 Kept response is pushed with inst_pc = rsp_pc; rsp_pc then advances by 4, with the same wrap as fetch_pc.
REQ-022 Queue is FIFO, DEPTH entries; push and pop in the same cycle are both honored, including when full or empty-with-push; no bypass, so a pushed entry is visible at the head no earlier than the next cycle.
REQ-023 inst_valid high iff queue count > 0; inst_data and inst_pc are stable while inst_valid is high and inst_ready is low.
REQ-024 On redirect_valid, next cycle: queue empty; fetch_pc and rsp_pc = {redirect_pc[31:2], 2'b00}; discard_cnt = outstanding minus any response arriving in that same cycle.
REQ-025 A consume in the redirect cycle completes normally; a response in the redirect cycle is dropped.
REQ-026 While discard_cnt > 0, each imem_rsp_valid is dropped (not pushed) and decrements discard_cnt.
REQ-027 A redirect while discard_cnt > 0 recomputes discard_cnt per REQ-024; consecutive redirects are legal, and the last one wins.
REQ-028 Response with the queue full and discard_cnt = 0 is unreachable by REQ-018; the bench asserts it never occurs.
REQ-029 Each entry's inst_pc + 4 equals the next entry's inst_pc (mod 2^32) between redirects.

Reset
REQ-030 While rst_n low: imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, queue count = 0, outstanding = 0, discard_cnt = 0, fetch_pc = rsp_pc = RESET_PC.
REQ-031 First request is issued in the first cycle after rst_n deasserts, with imem_req_addr = RESET_PC.
REQ-032 Reset asserted mid-operation abandons in-flight requests; responses to those requests after reset are an environment error and are not required to be handled.

Verification
REQ-033 Reset release, imem_req_ready = 1, memory latency 1, inst_ready = 1 -> addresses 8000_0000, 8000_0004, ...; inst_pc sequence matches, and the first inst_valid appears 2 cycles after the first accept.
REQ-034 inst_ready = 0, memory latency 3, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid stays 0 and inst_valid stays 1; one consume -> exactly one new request.
REQ-035 3 requests outstanding, then redirect to 0000_1003 -> the next 3 responses are dropped; the next request addr is 0000_1000 and the first delivered inst_pc = 0000_1000.
REQ-036 Redirect in the same cycle as a response and a consume -> consume completes, response dropped, discard_cnt = outstanding - 1, queue empty the next cycle.
REQ-037 Redirect to FFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc follows the same wrap.
REQ-038 rst_n pulsed low mid-stream -> all outputs match REQ-030 asynchronously, then restart at RESET_PC.
